// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush/bubble arbitration with a data-memory
// wait watchdog and saturating stall/flush statistics.
`default_nettype none

module hazard_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRt,
  input  logic        exMemRead,
  input  logic [4:0]  exRd,
  input  logic        branchTaken,
  input  logic        dmemReq,
  input  logic        dmemReady,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexWrite,
  output logic        exmemWrite,
  output logic        idexBubble,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        memwbBubble,
  output logic        memError,
  output logic [15:0] stallCycles,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_ERROR   = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      state_q;
  logic [7:0]  waitCnt_q;
  logic        memError_q;
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  logic memBusy;
  logic freeze;
  logic loadUse;

  assign memBusy = dmemReq && !dmemReady;
  assign freeze  = memBusy || (state_q == S_ERROR);
  assign loadUse = exMemRead && (exRd != 5'd0) &&
                   ((idRs == exRd) || (idUsesRt && (idRt == exRd)));

  // Release happens in the dmemReady cycle itself since freeze is purely combinational.
  always_comb begin
    pcWrite     = 1'b0;
    ifidWrite   = 1'b0;
    idexWrite   = 1'b0;
    exmemWrite  = 1'b0;
    idexBubble  = 1'b0;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    memwbBubble = 1'b0;
    if (reset) begin
      pcWrite = 1'b0;
    end else if (freeze) begin
      memwbBubble = 1'b1;
    end else if (branchTaken) begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
    end else if (loadUse) begin
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      idexBubble = 1'b1;
    end else begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
    end
  end

  assign memError    = memError_q && !reset;
  assign stallCycles = reset ? 16'd0 : stall_q;
  assign flushCount  = reset ? 16'd0 : flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      waitCnt_q  <= 8'd0;
      memError_q <= 1'b0;
      stall_q    <= 16'd0;
      flush_q    <= 16'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (memBusy) begin
            state_q   <= S_MEMWAIT;
            waitCnt_q <= 8'd1;
          end
        end
        S_MEMWAIT: begin
          if (!memBusy) begin
            state_q   <= S_RUN;
            waitCnt_q <= 8'd0;
          end else if (waitCnt_q == 8'(MEM_TIMEOUT)) begin
            state_q    <= S_ERROR;
            memError_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + 8'd1;
          end
        end
        S_ERROR: begin
          state_q    <= S_ERROR;
          memError_q <= 1'b1;
        end
        default: begin
          state_q   <= S_RUN;
          waitCnt_q <= 8'd0;
        end
      endcase
      if (!pcWrite && (stall_q != CNT_MAX)) stall_q <= stall_q + 16'd1;
      if (ifidFlush && (flush_q != CNT_MAX)) flush_q <= flush_q + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scenarios plus randomized stimulus checked every
// cycle against a rule-level reference model.
`default_nettype none

module tb_hazard_control;

  localparam int unsigned MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  idRs = '0, idRt = '0, exRd = '0;
  logic        idUsesRt = 1'b0, exMemRead = 1'b0, branchTaken = 1'b0;
  logic        dmemReq = 1'b0, dmemReady = 1'b0;
  logic        pcWrite, ifidWrite, idexWrite, exmemWrite;
  logic        idexBubble, ifidFlush, idexFlush, memwbBubble, memError;
  logic [15:0] stallCycles, flushCount;

  hazard_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .exMemRead(exMemRead), .exRd(exRd), .branchTaken(branchTaken),
    .dmemReq(dmemReq), .dmemReady(dmemReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .idexBubble(idexBubble), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .memwbBubble(memwbBubble), .memError(memError),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: length of the current run of unserved memory cycles.
  int m_run = 0;
  bit m_err = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  // Bundle order: pcWrite ifidWrite idexWrite exmemWrite idexBubble ifidFlush idexFlush memwbBubble
  function automatic logic [7:0] exp_bundle();
    bit hazard;
    hazard = exMemRead && exRd != 0 &&
             (idRs == exRd || (idUsesRt && idRt == exRd));
    if (reset)                            return 8'b0000_0000;
    if ((dmemReq && !dmemReady) || m_err) return 8'b0000_0001;
    if (branchTaken)                      return 8'b1111_0110;
    if (hazard)                           return 8'b0011_1000;
    return 8'b1111_0000;
  endfunction

  always @(posedge clk) begin
    logic [7:0] e;
    e = exp_bundle();
    if (reset) begin
      m_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (dmemReq && !dmemReady) m_run++;
      else                       m_run = 0;
      if (m_run >= MEM_TIMEOUT + 1) m_err = 1'b1;
      if (!e[7] && m_stall < 65535) m_stall++;
      if (e[2] && m_flush < 65535) m_flush++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bundle", int'({pcWrite, ifidWrite, idexWrite, exmemWrite,
                          idexBubble, ifidFlush, idexFlush, memwbBubble}),
          int'(exp_bundle()));
      chk("memError", int'(memError), (!reset && m_err) ? 1 : 0);
      chk("stallCycles", int'(stallCycles), reset ? 0 : m_stall);
      chk("flushCount", int'(flushCount), reset ? 0 : m_flush);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    idRs = '0; idRt = '0; exRd = '0; idUsesRt = 1'b0; exMemRead = 1'b0;
    branchTaken = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    cyc();
    @(negedge clk);
    chk("rst_pcWrite", int'(pcWrite), 0);
    chk("rst_stall", int'(stallCycles), 0);
    chk("rst_memError", int'(memError), 0);
    cyc();
    reset = 1'b0;
  endtask

  task automatic force_error();
    dmemReq = 1'b1; dmemReady = 1'b0;
    repeat (MEM_TIMEOUT + 1) cyc();
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;

    // Load into r5 followed by a dependent read.
    do_reset();
    exMemRead = 1'b1; exRd = 5'd5; idRs = 5'd5;
    @(negedge clk);
    chk("lu_pcWrite", int'(pcWrite), 0);
    chk("lu_ifidWrite", int'(ifidWrite), 0);
    chk("lu_idexBubble", int'(idexBubble), 1);
    cyc(); clear_in();
    @(negedge clk);
    chk("lu_next_pcWrite", int'(pcWrite), 1);
    chk("lu_stall", int'(stallCycles), 1);

    // r0 destination never hazards.
    do_reset();
    exMemRead = 1'b1; exRd = 5'd0; idRs = 5'd0;
    @(negedge clk);
    chk("r0_pcWrite", int'(pcWrite), 1);
    chk("r0_idexWrite", int'(idexWrite), 1);
    cyc(); clear_in();
    @(negedge clk);
    chk("r0_stall", int'(stallCycles), 0);

    // Branch wins over load-use.
    do_reset();
    exMemRead = 1'b1; exRd = 5'd7; idRt = 5'd7; idUsesRt = 1'b1; branchTaken = 1'b1;
    @(negedge clk);
    chk("br_ifidFlush", int'(ifidFlush), 1);
    chk("br_idexFlush", int'(idexFlush), 1);
    chk("br_idexBubble", int'(idexBubble), 0);
    cyc(); clear_in();
    @(negedge clk);
    chk("br_flush", int'(flushCount), 1);
    chk("br_stall", int'(stallCycles), 0);

    // Three memory wait cycles, release in the fourth.
    do_reset();
    dmemReq = 1'b1; dmemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_memwbBubble", int'(memwbBubble), 1);
      cyc();
    end
    dmemReady = 1'b1;
    @(negedge clk);
    chk("mw_release_pcWrite", int'(pcWrite), 1);
    chk("mw_release_memwb", int'(memwbBubble), 0);
    cyc(); clear_in();
    @(negedge clk);
    chk("mw_stall", int'(stallCycles), 3);
    chk("mw_memError", int'(memError), 0);

    // Timeout into ERROR, then recover through reset.
    do_reset();
    force_error();
    dmemReq = 1'b0;
    @(negedge clk);
    chk("to_memError", int'(memError), 1);
    chk("to_frozen", int'(pcWrite), 0);
    do_reset();
    @(negedge clk);
    chk("to_rec_memError", int'(memError), 0);
    chk("to_rec_pcWrite", int'(pcWrite), 1);

    // Saturation of the stall counter.
    do_reset();
    force_error();
    clear_in();
    repeat (70000) cyc();
    @(negedge clk);
    chk("sat_stall", int'(stallCycles), 16'hFFFF);

    // Randomized traffic, with occasional long memory waits and resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      idRs        = 5'($urandom_range(0, 3));
      idRt        = 5'($urandom_range(0, 3));
      exRd        = 5'($urandom_range(0, 3));
      idUsesRt    = 1'($urandom_range(0, 1));
      exMemRead   = ($urandom_range(0, 99) < 40);
      branchTaken = ($urandom_range(0, 99) < 15);
      dmemReq     = ($urandom_range(0, 99) < ((n % 1000) < 500 ? 30 : 95));
      dmemReady   = ($urandom_range(0, 99) < ((n % 1000) < 500 ? 60 : 3));
      reset       = ($urandom_range(0, 999) < 4);
      cyc();
    end
    reset = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
